// File: rtl/updown_counter_param.sv
// W-bit bus-programmed up/down counter: bounce or wrap stepping between LLR and
// ULR, cycle counting against CCR, abort, and a sticky configuration error.
module updown_counter_param #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ncs,
   input  logic         nwr,
   input  logic         nrd,
   input  logic [2:0]   addr,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   input  logic         start,
   output logic [W-1:0] cout,
   output logic         dir,
   output logic         busy,
   output logic         ec,
   output logic         err
);

   localparam logic [2:0] A_PLR    = 3'd0;
   localparam logic [2:0] A_ULR    = 3'd1;
   localparam logic [2:0] A_LLR    = 3'd2;
   localparam logic [2:0] A_CCR    = 3'd3;
   localparam logic [2:0] A_CTRL   = 3'd4;
   localparam logic [2:0] A_STATUS = 3'd5;
   localparam logic [2:0] A_CNT    = 3'd6;
   localparam logic [2:0] A_INC    = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ERR
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0] plr_q, ulr_q, llr_q, ccr_q;
   logic         mode_q, init_dir_q;
   logic [W-1:0] cout_q, inc_q;
   logic         dir_q, ec_q, start_q;
   logic [W:0]   step_q;

   logic         wr, rd, start_edge, abort_req, cfg_wr, cfg_bad;
   logic [W:0]   span, period, step_nxt;
   logic         step_dir, nxt_dir, period_end, run_done;
   logic [W-1:0] nxt_cout, inc_nxt;

   assign wr         = ~ncs & ~nwr & nrd;
   assign rd         = ~ncs & nwr & ~nrd;
   assign start_edge = start & ~start_q;
   assign abort_req  = wr && (addr == A_CTRL) && wdata[2];
   // Configuration is frozen during a run; only an abort-carrying CTRL write gets through.
   assign cfg_wr     = wr && (addr <= A_CTRL) && ((state_q != S_RUN) || abort_req);
   assign cfg_bad    = (plr_q < llr_q) | (plr_q > ulr_q) | (llr_q == ulr_q);

   // Period needs W+1 bits: a full-range wrap spans 2^W steps.
   assign span       = {1'b0, ulr_q} - {1'b0, llr_q};
   assign period     = mode_q ? (span + 1'b1) : {span[W-1:0], 1'b0};
   assign step_nxt   = step_q + 1'b1;
   assign period_end = (step_nxt == period);
   assign inc_nxt    = inc_q + 1'b1;
   assign run_done   = period_end && (ccr_q != '0) && (inc_nxt == ccr_q);

   // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      step_dir = dir_q;
      nxt_dir  = dir_q;
      nxt_cout = cout_q;
      if (mode_q) begin
         if (dir_q) nxt_cout = (cout_q == ulr_q) ? llr_q : cout_q + 1'b1;
         else       nxt_cout = (cout_q == llr_q) ? ulr_q : cout_q - 1'b1;
      end else begin
         // Sitting on a limit with the wrong direction: turn around before stepping.
         if (dir_q && (cout_q == ulr_q))       step_dir = 1'b0;
         else if (!dir_q && (cout_q == llr_q)) step_dir = 1'b1;
         if (step_dir) begin
            nxt_cout = cout_q + 1'b1;
            nxt_dir  = (nxt_cout != ulr_q);
         end else begin
            nxt_cout = cout_q - 1'b1;
            nxt_dir  = (nxt_cout == llr_q);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_edge) state_d = cfg_bad ? S_ERR : S_RUN;
         S_RUN:   if (abort_req || run_done) state_d = S_IDLE;
         S_ERR:   if (cfg_wr) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         plr_q      <= '0;
         ulr_q      <= '1;
         llr_q      <= '0;
         ccr_q      <= '0;
         mode_q     <= 1'b0;
         init_dir_q <= 1'b1;
         cout_q     <= '0;
         dir_q      <= 1'b1;
         inc_q      <= '0;
         step_q     <= '0;
         ec_q       <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         start_q <= start;
         ec_q    <= 1'b0;

         if (cfg_wr) begin
            case (addr)
               A_PLR:   plr_q <= wdata;
               A_ULR:   ulr_q <= wdata;
               A_LLR:   llr_q <= wdata;
               A_CCR:   ccr_q <= wdata;
               A_CTRL: begin
                  mode_q     <= wdata[0];
                  init_dir_q <= wdata[1];
               end
               default: ;
            endcase
         end

         // Run launch reads the pre-write register values, so a same-cycle write is harmless.
         case (state_q)
            S_IDLE: begin
               if (start_edge && !cfg_bad) begin
                  cout_q <= plr_q;
                  dir_q  <= init_dir_q;
                  inc_q  <= '0;
                  step_q <= '0;
               end
            end
            S_RUN: begin
               if (!abort_req) begin
                  cout_q <= nxt_cout;
                  dir_q  <= nxt_dir;
                  if (period_end) begin
                     step_q <= '0;
                     inc_q  <= inc_nxt;
                     ec_q   <= run_done;
                  end else begin
                     step_q <= step_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign cout = cout_q;
   assign dir  = dir_q;
   assign ec   = ec_q;
   assign busy = (state_q == S_RUN);
   assign err  = (state_q == S_ERR);

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (addr)
            A_PLR:    rdata = plr_q;
            A_ULR:    rdata = ulr_q;
            A_LLR:    rdata = llr_q;
            A_CCR:    rdata = ccr_q;
            A_CTRL:   rdata[1:0] = {init_dir_q, mode_q};
            A_STATUS: rdata[3:0] = {busy, err, ec_q, dir_q};
            A_CNT:    rdata = cout_q;
            A_INC:    rdata = inc_q;
            default:  rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: bounce, wrap, error, abort, reset,
// simultaneous start/write, and the W=4 full-range limit case.
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       ncs, nwr, nrd, start;
   logic [2:0] addr;
   logic [7:0] wdata, rdata, cout;
   logic       dir, busy, ec, err;

   logic       ncs4, nwr4, nrd4, start4;
   logic [2:0] addr4;
   logic [3:0] wdata4, rdata4, cout4;
   logic       dir4, busy4, ec4, err4;

   int checks = 0;
   int errors = 0;

   logic [7:0] b_cout [9] = '{8'd5, 8'd6, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd4, 8'd5};
   logic       b_dir  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [7:0] w_cout [5] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2};

   always #5 clk = ~clk;

   updown_counter_param #(.W(8)) u_dut (
      .clk(clk), .rst(rst), .ncs(ncs), .nwr(nwr), .nrd(nrd), .addr(addr),
      .wdata(wdata), .rdata(rdata), .start(start), .cout(cout), .dir(dir),
      .busy(busy), .ec(ec), .err(err)
   );

   updown_counter_param #(.W(4)) u_dut4 (
      .clk(clk), .rst(rst), .ncs(ncs4), .nwr(nwr4), .nrd(nrd4), .addr(addr4),
      .wdata(wdata4), .rdata(rdata4), .start(start4), .cout(cout4), .dir(dir4),
      .busy(busy4), .ec(ec4), .err(err4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr8(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      ncs = 1'b0; nwr = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      ncs = 1'b1; nwr = 1'b1;
   endtask

   task automatic rd8(input logic [2:0] a, input string tag, input logic [31:0] exp);
      ncs = 1'b0; nrd = 1'b0; addr = a;
      #1;
      check(tag, 32'(rdata), exp);
      ncs = 1'b1; nrd = 1'b1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ncs = 1'b1; nwr = 1'b1; nrd = 1'b1;
      addr = '0; wdata = '0;
      start4 = 1'b0; ncs4 = 1'b1; nwr4 = 1'b1; nrd4 = 1'b1;
      addr4 = '0; wdata4 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_cout", 32'(cout), 32'd0);
      check("rst_dir", 32'(dir), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ec", 32'(ec), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata_idle", 32'(rdata), 32'd0);
      rd8(3'd1, "rst_ulr", 32'hFF);

      // Bounce: PLR=5 LLR=3 ULR=7 CCR=2, bounce, init up
      wr8(3'd0, 8'd5); wr8(3'd2, 8'd3); wr8(3'd1, 8'd7); wr8(3'd3, 8'd2); wr8(3'd4, 8'h02);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("bounce_cout_c%0d", i + 1), 32'(cout), 32'(b_cout[i]));
         check($sformatf("bounce_dir_c%0d", i + 1), 32'(dir), 32'(b_dir[i]));
         check($sformatf("bounce_busy_c%0d", i + 1), 32'(busy), 32'd1);
         if (i < 8) @(negedge clk);
      end
      rd8(3'd7, "bounce_inc_c9", 32'd1);
      repeat (8) @(negedge clk);
      check("bounce_cout_c17", 32'(cout), 32'd5);
      check("bounce_ec_c17", 32'(ec), 32'd1);
      check("bounce_busy_c17", 32'(busy), 32'd0);
      rd8(3'd7, "bounce_inc_c17", 32'd2);
      @(negedge clk);
      check("bounce_ec_c18", 32'(ec), 32'd0);
      check("bounce_cout_c18", 32'(cout), 32'd5);

      // Wrap: PLR=2 LLR=0 ULR=3 CCR=1, wrap, init down
      wr8(3'd0, 8'd2); wr8(3'd2, 8'd0); wr8(3'd1, 8'd3); wr8(3'd3, 8'd1); wr8(3'd4, 8'h01);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("wrap_cout_c%0d", i + 1), 32'(cout), 32'(w_cout[i]));
         check($sformatf("wrap_dir_c%0d", i + 1), 32'(dir), 32'd0);
         check($sformatf("wrap_ec_c%0d", i + 1), 32'(ec), 32'(i == 4));
         check($sformatf("wrap_busy_c%0d", i + 1), 32'(busy), 32'(i != 4));
         if (i < 4) @(negedge clk);
      end

      // Error: PLR above ULR
      wr8(3'd1, 8'd7); wr8(3'd0, 8'd9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_err", 32'(err), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      check("err_cout_held", 32'(cout), 32'd2);
      rd8(3'd5, "err_status", 32'h4);
      wr8(3'd0, 8'd6);
      check("err_cleared", 32'(err), 32'd0);
      rd8(3'd0, "err_plr_applied", 32'd6);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_rerun_busy", 32'(busy), 32'd1);
      check("err_rerun_cout", 32'(cout), 32'd6);
      check("err_rerun_dir", 32'(dir), 32'd0);
      wr8(3'd4, 8'h06);
      check("err_abort_busy", 32'(busy), 32'd0);
      check("err_abort_cout", 32'(cout), 32'd5);

      // Abort: free-run from PLR=3, bounce up, LLR=0 ULR=7
      wr8(3'd3, 8'd0); wr8(3'd0, 8'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort_cout_c1", 32'(cout), 32'd3);
      check("abort_busy_c1", 32'(busy), 32'd1);
      wr8(3'd0, 8'd1);
      check("abort_cout_c3", 32'(cout), 32'd5);
      wr8(3'd4, 8'h06);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cout_held", 32'(cout), 32'd6);
      check("abort_ec", 32'(ec), 32'd0);
      @(negedge clk);
      check("abort_cout_held2", 32'(cout), 32'd6);
      check("abort_ec2", 32'(ec), 32'd0);
      rd8(3'd0, "abort_plr_ignored", 32'd3);
      rd8(3'd4, "abort_ctrl_selfclear", 32'h2);

      // Reset mid-run
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rstrun_cout_c1", 32'(cout), 32'd3);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstrun_cout", 32'(cout), 32'd0);
      check("rstrun_dir", 32'(dir), 32'd1);
      check("rstrun_busy", 32'(busy), 32'd0);
      check("rstrun_ec", 32'(ec), 32'd0);
      rd8(3'd1, "rstrun_ulr", 32'hFF);
      rd8(3'd7, "rstrun_inc", 32'd0);
      rd8(3'd0, "rstrun_plr", 32'd0);

      // Start edge and PLR write in the same cycle: run uses the old PLR
      start = 1'b1; ncs = 1'b0; nwr = 1'b0; addr = 3'd0; wdata = 8'h10;
      @(negedge clk);
      start = 1'b0; ncs = 1'b1; nwr = 1'b1;
      check("simul_busy", 32'(busy), 32'd1);
      check("simul_cout", 32'(cout), 32'd0);
      rd8(3'd0, "simul_plr", 32'h10);
      wr8(3'd4, 8'h06);
      check("simul_abort_busy", 32'(busy), 32'd0);

      // W=4 limit: LLR=0 ULR=15 PLR=15, bounce, init up
      @(negedge clk);
      ncs4 = 1'b0; nwr4 = 1'b0; addr4 = 3'd0; wdata4 = 4'd15;
      @(negedge clk);
      ncs4 = 1'b1; nwr4 = 1'b1;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      check("w4_cout_c1", 32'(cout4), 32'd15);
      check("w4_dir_c1", 32'(dir4), 32'd1);
      check("w4_busy_c1", 32'(busy4), 32'd1);
      @(negedge clk);
      check("w4_cout_c2", 32'(cout4), 32'd14);
      check("w4_dir_c2", 32'(dir4), 32'd0);
      @(negedge clk);
      check("w4_cout_c3", 32'(cout4), 32'd13);
      check("w4_err", 32'(err4), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the 8-bit bus-programmed up/down bounce counter.
- Width is set by parameter. Adds a wrap mode and a selectable initial direction.
- Adds a control/status register map with readback of count and cycle progress, an explicit FSM, an abort, and a sticky configuration error.
- Sits on the local CPU bus (ncs/nwr/nrd strobes) and drives a count pattern to downstream logic.

Parameters:
W, 8, counter/register width in bits; legal range 4..32.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ncs  input  1  chip select, active low
nwr  input  1  write strobe, active low
nrd  input  1  read strobe, active low
addr  input  3  register address
wdata  input  W  write data
rdata  output  W  read data; 0 when no read is selected
start  input  1  run request; a rising edge starts a run
cout  output  W  current count
dir  output  1  direction of the next step: 1 = up, 0 = down
busy  output  1  high while in RUN
ec  output  1  end-of-count, one-cycle pulse
err  output  1  sticky configuration error

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Write: wr = ~ncs & ~nwr & nrd, applied at the clock edge.
- Read: rd = ~ncs & nwr & ~nrd; rdata is combinational.
- Register map:
  - 0 PLR: preload, reset 0.
  - 1 ULR: upper limit, reset all ones.
  - 2 LLR: lower limit, reset 0.
  - 3 CCR: cycle count, reset 0; 0 = free-run.
  - 4 CTRL: bit0 mode (0 bounce, 1 wrap); bit1 initial dir (1 up); bit2 abort (write-only, self-clearing). Reset: mode 0, init dir 1.
  - 5 STATUS (RO): {busy, err, ec, dir} in bits 3..0.
  - 6 CNT (RO): cout.
  - 7 INC (RO): completed cycles.
- Writes to addr 0–4 are ignored while busy, except a CTRL write with bit2=1. Writes to 5–7 are ignored.
- Start detect: start is registered each cycle; start_edge = start & ~start_q.
- cfg_bad = (PLR < LLR) | (PLR > ULR) | (LLR == ULR).
- FSM states: IDLE, RUN, ERR.
  - IDLE, start_edge, cfg_bad=0 → RUN. Next cycle: cout=PLR, dir=CTRL.bit1, inc=0, step counter=0, busy=1.
  - IDLE, start_edge, cfg_bad=1 → ERR with err=1. cout is unchanged.
  - ERR → IDLE on any register write (the write still applies); err clears at the same edge.
  - RUN, abort write → IDLE next edge. cout holds its value; ec stays 0.
  - RUN → IDLE when the completing step makes inc == CCR (CCR ≠ 0). ec=1 for exactly that one cycle; busy=0 in the same cycle.
- Start edges in RUN or ERR are ignored.
- Bounce stepping (in RUN, one step per cycle):
  - Moving up: cout+1. If the new value equals ULR, dir flips to 0.
  - Moving down: cout−1. If the new value equals LLR, dir flips to 1.
  - If cout already sits at a limit when a step is taken, dir is corrected before the step, so a step never leaves [LLR, ULR].
  - Period = 2·(ULR−LLR) steps.
- Wrap stepping: up from ULR goes to LLR; down from LLR goes to ULR. dir never changes. Period = ULR−LLR+1 steps.
- Cycle accounting:
  - Step counter is W+1 bits.
  - When the step counter reaches the period, it resets to 0 and inc increments. cout equals PLR at that moment.
  - With CCR=0, inc wraps modulo 2^W and the run continues until abort.
- Arithmetic: unsigned, W bits. cout never leaves [LLR, ULR].
- Simultaneous events: a start_edge and a register write in the same IDLE cycle → the run uses the pre-write register values; the write still lands.
- Reset mid-run: every register and output returns to its reset value at that edge; the FSM goes to IDLE.
- Output reset values: cout=0, dir=1, busy=0, ec=0, err=0, rdata=0.

Test Plan:
- Bounce, W=8. PLR=5, LLR=3, ULR=7, CCR=2, CTRL=0x02; start edge sampled at cycle 0.
  - Required: cout = 5,6,7,6,5,4,3,4,5 over cycles 1–9, with inc=1 at cycle 9.
  - Required: cout=5, ec=1, busy=0 at cycle 17; ec=0 at cycle 18.
- Wrap. PLR=2, LLR=0, ULR=3, CTRL=0x01 (down), CCR=1.
  - Required: cout = 2,1,0,3,2; ec pulses on the cycle cout returns to 2; dir stays 0.
- Error. PLR=9, ULR=7.
  - Required: start edge → err=1, STATUS bit2=1, cout unchanged, busy=0.
  - Required: writing PLR=6 clears err; the next start edge runs.
- Abort. CCR=0, free-run; write CTRL with bit2=1 mid-run.
  - Required: busy=0 next cycle, cout held, ec=0.
  - Required: a PLR write while busy (before the abort) is ignored on readback.
- Reset. Assert rst mid-run.
  - Required: cout=0, dir=1, busy=0, ULR readback=0xFF, INC=0.
- Limit case, W=4. LLR=0, ULR=15, PLR=15, init up.
  - Required: first step gives cout=14 with dir=0; no overflow to 0.
